// File: rtl/cache_line_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM state encoding, default geometry and
// address helpers used by the fill controller and the tag/data arrays.
package cache_line_fill_fsm_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fill_state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_line_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is
// high while the count equals TERM.
module cache_line_fill_fsm_fill_counter #(
  parameter int W    = 3,
  parameter int TERM = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TERM));

endmodule

// File: rtl/cache_line_fill_fsm.sv
// Cache line-fill controller: issues a burst of WORDS reads for a missing line,
// streams returned words into the data array and writes the tag on the last one.
module cache_line_fill_fsm
  import cache_line_fill_fsm_pkg::*;
#(
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  WORDS   = DEF_WORDS,
  parameter int  TIMEOUT = 64,
  localparam int IDX_W   = clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] line_base,
  output logic              done,
  output logic              timeout_err
);

  localparam int BPW   = DATA_W / 8;
  localparam int OFF_W = clog2(WORDS * BPW);
  localparam bit TO_EN = (TIMEOUT > 0);
  // The gap counter reads 0 in the first cycle after a return, so TIMEOUT
  // elapsed cycles correspond to a count of TIMEOUT-1.
  localparam int TO_W    = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  localparam int TO_TERM = TO_EN ? TIMEOUT - 1 : 0;

  fill_state_t      state, state_next;
  logic [IDX_W-1:0] issue_count, ret_count;
  logic [TO_W-1:0]  to_count_unused;
  logic             issue_last, ret_last, to_expired;
  logic             busy, accept, ret_fire, fill_end, timeout_hit, cnt_clr;

  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && miss_detected;
  assign ret_fire = busy && mem_data_valid;
  assign fill_end = ret_fire && ret_last;
  // A word arriving in the expiry cycle is still on time.
  assign timeout_hit = TO_EN && busy && to_expired && !mem_data_valid;
  // Counters sit at zero whenever the controller is (or is about to be) idle.
  assign cnt_clr = (state_next == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_base <= '0;
    end else begin
      state <= state_next;
      if (accept) line_base <= ADDR_W'(line_align(64'(miss_address), OFF_W));
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_next       = state;
    fsm_busy         = busy;
    mem_en           = 1'b0;
    mem_addr         = '0;
    write_data_array = ret_fire;
    fill_word_idx    = '0;
    fill_data        = mem_data;
    write_tag_array  = fill_end;
    done             = fill_end;
    timeout_err      = timeout_hit;

    case (state)
      IDLE: begin
        if (miss_detected) state_next = ISSUE;
      end
      ISSUE: begin
        mem_en        = 1'b1;
        mem_addr      = line_base + ADDR_W'(issue_count) * ADDR_W'(BPW);
        fill_word_idx = ret_count;
        if (fill_end || timeout_hit) state_next = IDLE;
        else if (issue_last)         state_next = DRAIN;
      end
      DRAIN: begin
        fill_word_idx = ret_count;
        if (fill_end || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  cache_line_fill_fsm_fill_counter #(.W(IDX_W), .TERM(WORDS - 1)) issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (state == ISSUE),
    .count (issue_count),
    .tc    (issue_last)
  );

  cache_line_fill_fsm_fill_counter #(.W(IDX_W), .TERM(WORDS - 1)) ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (ret_fire),
    .count (ret_count),
    .tc    (ret_last)
  );

  cache_line_fill_fsm_fill_counter #(.W(TO_W), .TERM(TO_TERM)) to_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr || ret_fire),
    .en    (busy && TO_EN),
    .count (to_count_unused),
    .tc    (to_expired)
  );

endmodule

// File: tb/tb_cache_line_fill_fsm.sv
// Bench for cache_line_fill_fsm: a default instance and a 4x32-bit instance,
// each compared every cycle against a transaction-level model of the fill.
module tb_cache_line_fill_fsm;

  localparam int NI      = 2;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic busy, en, wda, wta, done, to;
    logic [63:0] addr, idx, data, base;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        miss0, v0, busy0, en0, wda0, wta0, done0, to0;
  logic [15:0] addr0, d0, maddr0, fd0, base0;
  logic [2:0]  idx0;
  logic        miss1, v1, busy1, en1, wda1, wta1, done1, to1;
  logic [31:0] addr1, d1, maddr1, fd1, base1;
  logic [1:0]  idx1;

  cache_line_fill_fsm dut0 (
    .clk(clk), .rst(rst), .miss_detected(miss0), .miss_address(addr0),
    .mem_data_valid(v0), .mem_data(d0), .fsm_busy(busy0), .mem_en(en0),
    .mem_addr(maddr0), .write_data_array(wda0), .fill_word_idx(idx0),
    .fill_data(fd0), .write_tag_array(wta0), .line_base(base0),
    .done(done0), .timeout_err(to0)
  );

  cache_line_fill_fsm #(.ADDR_W(32), .DATA_W(32), .WORDS(4), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst(rst), .miss_detected(miss1), .miss_address(addr1),
    .mem_data_valid(v1), .mem_data(d1), .fsm_busy(busy1), .mem_en(en1),
    .mem_addr(maddr1), .write_data_array(wda1), .fill_word_idx(idx1),
    .fill_data(fd1), .write_tag_array(wta1), .line_base(base1),
    .done(done1), .timeout_err(to1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int words_of(input int k);  return (k == 0) ? 8 : 4;   endfunction
  function automatic int bpw_of(input int k);    return (k == 0) ? 2 : 4;   endfunction
  function automatic int aw_of(input int k);     return (k == 0) ? 16 : 32; endfunction

  // Memory responder: each request returns a word lat[k] cycles later while budget lasts.
  int lat[NI];
  int budget[NI];
  bit spur[NI];
  int due0[$];
  int due1[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    v0 = 1'b0;
    v1 = 1'b0;
    if (due0.size() > 0 && due0[0] == cyc) begin
      void'(due0.pop_front());
      if (budget[0] > 0) begin v0 = 1'b1; budget[0]--; end
    end
    if (due1.size() > 0 && due1[0] == cyc) begin
      void'(due1.pop_front());
      if (budget[1] > 0) begin v1 = 1'b1; budget[1]--; end
    end
    if (spur[0]) v0 = 1'b1;
    d0 = 16'h1100 + 16'(cyc * 3);
    d1 = 32'hC0DE_0000 + 32'(cyc);
  end

  // Transaction-level model: a fill is "busy" with counts of issued/returned words.
  bit          m_busy[NI];
  logic [63:0] m_base[NI];
  int          m_iss[NI], m_ret[NI], m_gap[NI];

  task automatic model_cycle(input int k, input bit r, input bit miss, input logic [63:0] a,
                             input bit v, input logic [63:0] d, input obs_t o);
    bit e_busy, e_en, e_wda, e_last, e_to;
    logic [63:0] e_addr, e_idx, amask, lmask;
    string p;
    p      = $sformatf("i%0d c%0d", k, cyc);
    amask  = (64'd1 << aw_of(k)) - 64'd1;
    lmask  = 64'(words_of(k) * bpw_of(k)) - 64'd1;
    e_busy = !r && m_busy[k];
    e_en   = e_busy && (m_iss[k] < words_of(k));
    e_addr = e_en ? ((m_base[k] + 64'(m_iss[k] * bpw_of(k))) & amask) : 64'd0;
    e_wda  = e_busy && v;
    e_idx  = e_busy ? 64'(m_ret[k]) : 64'd0;
    e_last = e_wda && (m_ret[k] == words_of(k) - 1);
    e_to   = e_busy && !v && (m_gap[k] == TIMEOUT);
    check({p, " fsm_busy"}, 64'(o.busy), 64'(e_busy));
    check({p, " mem_en"}, 64'(o.en), 64'(e_en));
    check({p, " mem_addr"}, o.addr, e_addr);
    check({p, " write_data_array"}, 64'(o.wda), 64'(e_wda));
    check({p, " fill_word_idx"}, o.idx, e_idx);
    check({p, " fill_data"}, o.data, d);
    check({p, " write_tag_array"}, 64'(o.wta), 64'(e_last));
    check({p, " done"}, 64'(o.done), 64'(e_last));
    check({p, " timeout_err"}, 64'(o.to), 64'(e_to));
    check({p, " line_base"}, o.base, r ? 64'd0 : m_base[k]);
    if (r) begin
      m_busy[k] = 1'b0; m_base[k] = '0; m_iss[k] = 0; m_ret[k] = 0; m_gap[k] = 0;
    end else if (!m_busy[k]) begin
      if (miss) begin
        m_busy[k] = 1'b1; m_base[k] = a & ~lmask; m_iss[k] = 0; m_ret[k] = 0; m_gap[k] = 1;
      end
    end else if (e_last || e_to) begin
      m_busy[k] = 1'b0;
    end else begin
      if (e_en) m_iss[k]++;
      if (v) begin m_ret[k]++; m_gap[k] = 1; end
      else m_gap[k]++;
    end
  endtask

  // Event logs for the literal expectations of each directed test.
  logic [63:0] en_addr_log[NI][16];
  int          en_cyc_log[NI][16];
  logic [63:0] idx_log[NI][16];
  int n_en[NI], n_wda[NI], n_wta[NI], n_to[NI], n_v[NI];
  int done_cyc[NI], to_cyc[NI], fall_cyc[NI];
  bit overlap[NI], prev_busy[NI];

  task automatic clear_logs(input int k);
    n_en[k] = 0; n_wda[k] = 0; n_wta[k] = 0; n_to[k] = 0; n_v[k] = 0;
    done_cyc[k] = -1; to_cyc[k] = -1; fall_cyc[k] = -1; overlap[k] = 1'b0;
  endtask

  task automatic log_obs(input int k, input obs_t o, input bit v);
    if (o.en) begin
      if (n_en[k] < 16) begin en_addr_log[k][n_en[k]] = o.addr; en_cyc_log[k][n_en[k]] = cyc; end
      n_en[k]++;
    end
    if (o.wda) begin
      if (n_wda[k] < 16) idx_log[k][n_wda[k]] = o.idx;
      n_wda[k]++;
      if (o.en) overlap[k] = 1'b1;
    end
    if (o.wta) n_wta[k]++;
    if (o.done) done_cyc[k] = cyc;
    if (o.to) begin to_cyc[k] = cyc; n_to[k]++; end
    if (v) n_v[k]++;
    if (prev_busy[k] && !o.busy) fall_cyc[k] = cyc;
    prev_busy[k] = o.busy;
  endtask

  always @(negedge clk) begin
    obs_t o0, o1;
    o0 = '{busy: busy0, en: en0, wda: wda0, wta: wta0, done: done0, to: to0,
           addr: 64'(maddr0), idx: 64'(idx0), data: 64'(fd0), base: 64'(base0)};
    o1 = '{busy: busy1, en: en1, wda: wda1, wta: wta1, done: done1, to: to1,
           addr: 64'(maddr1), idx: 64'(idx1), data: 64'(fd1), base: 64'(base1)};
    if (!rst && en0) due0.push_back(cyc + lat[0]);
    if (!rst && en1) due1.push_back(cyc + lat[1]);
    log_obs(0, o0, v0);
    log_obs(1, o1, v1);
    model_cycle(0, rst, miss0, 64'(addr0), v0, 64'(d0), o0);
    model_cycle(1, rst, miss1, 64'(addr1), v1, 64'(d1), o1);
  end

  task automatic start_fill(input int k, input logic [31:0] a, output int acc);
    @(posedge clk); #1;
    if (k == 0) begin miss0 = 1'b1; addr0 = a[15:0]; end
    else begin miss1 = 1'b1; addr1 = a; end
    acc = cyc;
    @(posedge clk); #1;
    miss0 = 1'b0;
    miss1 = 1'b0;
  endtask

  task automatic wait_fall(input int k, input int after, input int limit);
    int n;
    n = 0;
    while (fall_cyc[k] <= after && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (fall_cyc[k] <= after) begin
      checks++;
      errors++;
      $display("FAIL i%0d fill end: fsm_busy still high %0d cycles after cycle %0d, required low", k, limit, after);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, f_cyc;
    logic [31:0] exp_w[4];
    exp_w = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    for (int k = 0; k < NI; k++) begin
      lat[k] = 4; budget[k] = 1000; spur[k] = 1'b0; prev_busy[k] = 1'b0;
      m_busy[k] = 1'b0; m_base[k] = '0; m_iss[k] = 0; m_ret[k] = 0; m_gap[k] = 0;
      clear_logs(k);
    end
    lat[1] = 1;
    miss0 = 1'b0; addr0 = '0; miss1 = 1'b0; addr1 = '0;
    v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
    rst = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset fsm_busy", 64'(busy0), 64'd0);
    check("reset mem_addr", 64'(maddr0), 64'd0);
    check("reset line_base", 64'(base1), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Default geometry, latency 4, miss at 0x1236
    clear_logs(0);
    start_fill(0, 32'h1236, a_cyc);
    wait_fall(0, a_cyc, 60);
    check("t1 request count", 64'(n_en[0]), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 mem_addr %0d", i), en_addr_log[0][i], 64'h1230 + 64'(2 * i));
      check($sformatf("t1 request cycle %0d", i), 64'(en_cyc_log[0][i]), 64'(a_cyc + 1 + i));
      check($sformatf("t1 fill_word_idx %0d", i), idx_log[0][i], 64'(i));
    end
    check("t1 data writes", 64'(n_wda[0]), 64'd8);
    check("t1 tag writes", 64'(n_wta[0]), 64'd1);
    check("t1 done cycle", 64'(done_cyc[0]), 64'(a_cyc + 12));
    check("t1 busy low cycle", 64'(fall_cyc[0]), 64'(a_cyc + 13));
    check("t1 line_base", 64'(base0), 64'h1230);

    // 4 x 32-bit words, latency 1, line at the top of the address space
    clear_logs(1);
    start_fill(1, 32'hFFFF_FFFC, a_cyc);
    wait_fall(1, a_cyc, 40);
    check("t2 request count", 64'(n_en[1]), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2 mem_addr %0d", i), en_addr_log[1][i], 64'(exp_w[i]));
    check("t2 return overlaps issue", 64'(overlap[1]), 64'd1);
    check("t2 data writes", 64'(n_wda[1]), 64'd4);
    check("t2 done cycle", 64'(done_cyc[1]), 64'(a_cyc + 5));
    check("t2 busy low cycle", 64'(fall_cyc[1]), 64'(a_cyc + 6));

    // Returns stop after 5 words: timeout 64 cycles after the 5th
    clear_logs(0);
    budget[0] = 5;
    start_fill(0, 32'h4442, a_cyc);
    wait_fall(0, a_cyc, 150);
    check("t3 data writes", 64'(n_wda[0]), 64'd5);
    check("t3 timeout cycle", 64'(to_cyc[0]), 64'(a_cyc + 9 + 64));
    check("t3 timeout pulses", 64'(n_to[0]), 64'd1);
    check("t3 tag writes", 64'(n_wta[0]), 64'd0);
    check("t3 done", 64'(done_cyc[0]), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3 busy low cycle", 64'(fall_cyc[0]), 64'(a_cyc + 74));
    budget[0] = 1000;

    // miss held through completion; second address accepted right after
    clear_logs(0);
    @(posedge clk); #1;
    miss0 = 1'b1; addr0 = 16'h1000; a_cyc = cyc;
    @(posedge clk); #1;
    addr0 = 16'h2000;
    wait_fall(0, a_cyc, 60);
    f_cyc = fall_cyc[0];
    miss0 = 1'b0;
    check("t4 first fill end", 64'(f_cyc), 64'(a_cyc + 13));
    @(negedge clk);
    check("t4 second fill busy", 64'(busy0), 64'd1);
    check("t4 second line_base", 64'(base0), 64'h2000);
    check("t4 second first mem_addr", 64'(maddr0), 64'h2000);
    wait_fall(0, f_cyc, 60);
    check("t4 second fill end", 64'(fall_cyc[0]), 64'(f_cyc + 13));
    check("t4 tag writes", 64'(n_wta[0]), 64'd2);

    // Reset after three requests; late returns land in IDLE
    clear_logs(0);
    start_fill(0, 32'h3000, a_cyc);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("t5 requests before reset", 64'(n_en[0]), 64'd3);
    check("t5 reset fsm_busy", 64'(busy0), 64'd0);
    check("t5 reset mem_en", 64'(en0), 64'd0);
    check("t5 reset line_base", 64'(base0), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("t5 late returns seen", 64'(n_v[0]), 64'd3);
    check("t5 writes after reset", 64'(n_wda[0]), 64'd0);

    // Spurious returns in IDLE, then a fill that must start at index 0
    clear_logs(0);
    spur[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    spur[0] = 1'b0;
    check("t6 spurious writes", 64'(n_wda[0]), 64'd0);
    lat[0] = 2;
    start_fill(0, 32'h5678, a_cyc);
    wait_fall(0, a_cyc, 60);
    check("t6 first fill_word_idx", idx_log[0][0], 64'd0);
    check("t6 data writes", 64'(n_wda[0]), 64'd8);
    check("t6 done cycle", 64'(done_cyc[0]), 64'(a_cyc + 10));
    check("t6 line_base", 64'(base0), 64'h5670);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
